// File: rtl/syn_fifo_prog.sv
// syn_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and a
// selectable read mode (FWFT=0 registered read, FWFT=1 first-word-fall-through).
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   wr_en, data_in    write request and data
//   rd_en             read / pop request
//   clr_err           synchronous clear of overflow/underflow
//   data_out          read data (registered, or head of queue when FWFT=1)
//   valid_out         new word on data_out (FWFT=1: queue not empty)
//   full, empty       count == DEPTH / count == 0
//   almost_full       count >= AF_THRESH
//   almost_empty      count <= AE_THRESH
//   count             occupancy, $clog2(DEPTH)+1 bits
//   overflow          sticky: write attempted while full
//   underflow         sticky: read attempted while empty
module syn_fifo_prog #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATASIZE  = 4,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATASIZE-1:0]       data_in,
  input  logic                      rd_en,
  input  logic                      clr_err,
  output logic [DATASIZE-1:0]       data_out,
  output logic                      valid_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned ADDRSIZE = $clog2(DEPTH);
  localparam int unsigned CW       = ADDRSIZE + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  logic [DATASIZE-1:0] data_q,   data_d;
  logic                valid_q,  valid_d;
  logic                ovf_q,    ovf_d;
  logic                udf_q,    udf_d;

  logic [ADDRSIZE-1:0] wr_addr;
  logic [ADDRSIZE-1:0] rd_addr;
  logic [DATASIZE-1:0] rd_data;
  logic                wr_acc;
  logic                rd_acc;

  // Address is the low bits of the pointer; MSB only tracks wrap parity
  assign wr_addr = wr_ptr_q[ADDRSIZE-1:0];
  assign rd_addr = rd_ptr_q[ADDRSIZE-1:0];
  assign rd_data = mem[rd_addr];

  // Status decoded from registered count
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Acceptance uses the flags as registered before this edge (no bypass)
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Read-port view selected by mode
  assign data_out  = (FWFT != 0) ? rd_data : data_q;
  assign valid_out = (FWFT != 0) ? !empty  : valid_q;

  // Next-state logic for pointers, count, read register and error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
      data_d   = rd_data;
      valid_d  = 1'b1;
    end

    if (wr_acc && !rd_acc)      count_d = count_q + ONE_C;
    else if (rd_acc && !wr_acc) count_d = count_q - ONE_C;

    // clear wins over a same-cycle set
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_en && full)  ovf_d = 1'b1;
      if (rd_en && empty) udf_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_syn_fifo_prog.sv
// tb_syn_fifo_prog: drives a registered-read and an FWFT instance with the
// same stimulus and compares both against a queue-based reference model.
module tb_syn_fifo_prog;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] data_in;

  logic [DW-1:0] a_dout, b_dout;
  logic          a_valid, b_valid, a_full, b_full, a_empty, b_empty;
  logic          a_af, b_af, a_ae, b_ae, a_ovf, b_ovf, a_udf, b_udf;
  logic [3:0]    a_count, b_count;

  syn_fifo_prog #(.DEPTH(8), .DATASIZE(4), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_dut_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(a_dout), .valid_out(a_valid), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_udf));

  syn_fifo_prog #(.DEPTH(8), .DATASIZE(4), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(b_dout), .valid_out(b_valid), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_udf));

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_udf, m_valid;
  logic [DW-1:0] m_dout;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
  endtask

  // One clock edge of the FIFO as described behaviourally
  task automatic model_edge();
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_valid = 1'b0;
    if (rd_en && !was_empty) begin
      m_dout  = mq.pop_front();
      m_valid = 1'b1;
    end
    if (wr_en && !was_full) mq.push_back(data_in);
    if (clr_err) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr_en && was_full)  m_ovf = 1'b1;
      if (rd_en && was_empty) m_udf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, "/count"}, 32'(a_count), 32'(n));
    check({tag, "/full"},  32'(a_full),  32'(n == DEPTH));
    check({tag, "/empty"}, 32'(a_empty), 32'(n == 0));
    check({tag, "/af"},    32'(a_af),    32'(n >= 6));
    check({tag, "/ae"},    32'(a_ae),    32'(n <= 2));
    check({tag, "/ovf"},   32'(a_ovf),   32'(m_ovf));
    check({tag, "/udf"},   32'(a_udf),   32'(m_udf));
    check({tag, "/valid"}, 32'(a_valid), 32'(m_valid));
    check({tag, "/dout"},  32'(a_dout),  32'(m_dout));
    check({tag, "/f_count"}, 32'(b_count), 32'(n));
    check({tag, "/f_valid"}, 32'(b_valid), 32'(n != 0));
    check({tag, "/f_ovf"},   32'(b_ovf),   32'(m_ovf));
    check({tag, "/f_udf"},   32'(b_udf),   32'(m_udf));
    if (n != 0) check({tag, "/f_dout"}, 32'(b_dout), 32'(mq[0]));
  endtask

  // Drive one cycle of inputs (called at negedge), advance, then compare
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c, input string tag);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_ae",    32'(a_ae),    32'd1);
    rst = 1'b0;

    // 1: fill with 1..8, then overflow attempt
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, "t1_fill");
      check("t1_af", 32'(a_af), 32'(i >= 6));
    end
    check("t1_full", 32'(a_full), 32'd1);
    step(1'b1, 4'h9, 1'b0, 1'b0, "t1_ovf");
    check("t1_ovf_set", 32'(a_ovf), 32'd1);
    check("t1_count8",  32'(a_count), 32'd8);

    // 2: registered reads return 1..8 with valid pulses, then underflow
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "t2_read");
      check("t2_dout",  32'(a_dout),  32'(i));
      check("t2_valid", 32'(a_valid), 32'd1);
    end
    step(1'b0, '0, 1'b0, 1'b0, "t2_idle");
    check("t2_valid_drop", 32'(a_valid), 32'd0);
    check("t2_empty",      32'(a_empty), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, "t2_udf");
    check("t2_udf_set", 32'(a_udf), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "t2_clr");

    // 3: steady-state simultaneous traffic at count 3, wrapping pointers
    for (int i = 0; i < 3; i++) step(1'b1, DW'(i + 3), 1'b0, 1'b0, "t3_fill");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0, "t3_rw");
      check("t3_count3", 32'(a_count), 32'd3);
    end

    // 4: full with rd+wr, then empty with rd+wr, then clear
    while (mq.size() < DEPTH) step(1'b1, DW'($urandom), 1'b0, 1'b0, "t4_fill");
    step(1'b1, 4'hE, 1'b1, 1'b0, "t4_full_rw");
    check("t4_count7", 32'(a_count), 32'd7);
    check("t4_ovf",    32'(a_ovf),   32'd1);
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0, "t4_drain");
    step(1'b1, 4'h5, 1'b1, 1'b0, "t4_empty_rw");
    check("t4_count1", 32'(a_count), 32'd1);
    check("t4_udf",    32'(a_udf),   32'd1);
    step(1'b0, '0, 1'b0, 1'b1, "t4_clr");
    check("t4_clr_ovf", 32'(a_ovf), 32'd0);
    check("t4_clr_udf", 32'(a_udf), 32'd0);

    // 5: FWFT head visible before pop
    step(1'b0, '0, 1'b1, 1'b0, "t5_drain");
    step(1'b1, 4'hA, 1'b0, 1'b0, "t5_wr");
    check("t5_f_empty", 32'(b_empty), 32'd0);
    check("t5_f_valid", 32'(b_valid), 32'd1);
    check("t5_f_dout",  32'(b_dout),  32'hA);
    step(1'b0, '0, 1'b1, 1'b0, "t5_pop");
    check("t5_f_empty2", 32'(b_empty), 32'd1);

    // Random traffic: write-heavy, then read-heavy, then balanced
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic w, r, c;
        w = (ph == 0) ? ($urandom_range(0, 3) != 0) : (ph == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
        r = (ph == 1) ? ($urandom_range(0, 3) != 0) : (ph == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
        c = ($urandom_range(0, 15) == 0);
        step(w, DW'($urandom), r, c, "rand");
      end
    end

    // 6: asynchronous reset mid-burst at count 5
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0, "t6_drain");
    for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0, "t6_fill");
    step(1'b0, '0, 1'b1, 1'b0, "t6_rd");
    step(1'b1, 4'h7, 1'b1, 1'b0, "t6_rw");
    check("t6_count_pre", 32'(a_count), 32'd4);
    step(1'b1, 4'h8, 1'b0, 1'b0, "t6_wr");
    wr_en = 1'b1; data_in = 4'hC;
    #2 rst = 1'b1;
    #1;
    check("t6_count",  32'(a_count), 32'd0);
    check("t6_empty",  32'(a_empty), 32'd1);
    check("t6_dout",   32'(a_dout),  32'd0);
    check("t6_valid",  32'(a_valid), 32'd0);
    check("t6_af",     32'(a_af),    32'd0);
    check("t6_ovfudf", 32'({a_ovf, a_udf}), 32'd0);
    check("t6_f_count", 32'(b_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all("t6_after");
    for (int i = 0; i < 30; i++) step(1'($urandom), DW'($urandom), 1'($urandom), 1'b0, "t6_recover");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
